mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares the single unified memory port between the instruction-fetch requester (IF) and the
//  load/store requester (DM) of the multi-cycle CPU. Latches the winner's request and drives the
//  memory until mem_ready. Returns read data / write-ack to the owner only. Sits between the
//  control FSM datapath and the memory model.
// PARAMETERS
//  ADDR_W  32  address width, all address ports
//  DATA_W  32  data width; BE width is DATA_W/8
// PORTS
//  CLK        in   1        clock, rising edge
//  RSTn       in   1        reset, asynchronous, active-low
//  if_req     in   1        fetch request; held with if_addr until if_gnt
//  if_addr    in   ADDR_W   fetch address (always read, BE all ones)
//  if_gnt     out  1        fetch request accepted this cycle
//  if_rvalid  out  1        one-cycle pulse: fetch data valid
//  if_rdata   out  DATA_W   fetched word
//  dm_req     in   1        load/store request; held with payload until dm_gnt
//  dm_we      in   1        1 = store
//  dm_be      in   DATA_W/8 byte enables
//  dm_addr    in   ADDR_W   data address
//  dm_wdata   in   DATA_W   store data
//  dm_gnt     out  1        data request accepted this cycle
//  dm_rvalid  out  1        one-cycle pulse: load data valid / store done
//  dm_rdata   out  DATA_W   load data (0 for stores)
//  mem_req    out  1        memory request, held until mem_ready
//  mem_we, mem_be, mem_addr, mem_wdata  out  1/DATA_W/8/ADDR_W/DATA_W  latched payload
//  mem_ready  in   1        memory completes transaction this cycle
//  mem_rdata  in   DATA_W   valid when mem_ready && !mem_we
//  arb_busy   out  1        transaction outstanding (state != IDLE)
// BEHAVIOUR
//  - States: IDLE, WAIT_MEM, RESP. Reset -> IDLE; all registered outputs 0; gnt forced 0.
//  - IDLE: gnt combinational = selected req. On the edge with gnt: latch payload and owner
//    (IF: we=0, be=all ones); go WAIT_MEM. mem_req=1 from the next cycle.
//  - WAIT_MEM: mem_req and payload held stable. mem_ready sampled high -> capture mem_rdata
//    (0 if write), go RESP, mem_req=0 the following cycle. No gnt in WAIT_MEM or RESP.
//  - RESP: owner's rvalid=1 for exactly this cycle; other rvalid=0; go IDLE.
//  - Latency: gnt at N, mem_req N+1..N+k, mem_ready at N+k -> rvalid N+k+1, next gnt >= N+k+2.
//    Minimum gnt-to-rvalid is 2 cycles.
//  - Select (both req in IDLE): fixed priority, DM wins. A single requester always wins.
//  - A req deasserted before gnt is legal and ignored. A req raised while busy waits; no loss.
//  - rdata outputs hold their last value until the next RESP for that owner.
//  - mem_ready outside WAIT_MEM is ignored.
//  - RSTn low in any state: immediate IDLE, mem_req=0, outstanding transaction dropped,
//    no rvalid emitted.
// CONFIGURATION
//  MEM_ARB_RR_EN defined: round-robin. A 1-bit last_owner register, reset to IF, updated at
//    each gnt. On contention, grant the requester that was not last_owner.
//  Undefined: fixed DM priority, no last_owner register.
// STRUCTURE
//  - mem_arb_pkg: state encoding (IDLE/WAIT_MEM/RESP), owner constants (OWN_IF/OWN_DM),
//    DATA_W/8 BE width function.
//  - Sub-module mem_arb_pick (combinational): inputs if_req, dm_req, last_owner;
//    outputs sel_if, sel_dm. Contains the MEM_ARB_RR_EN variant.
//  - Top holds the FSM and payload/response registers.
// TESTING
//  1 Fetch only: if_addr=0x100, mem_ready after 3 cycles, mem_rdata=0x00500093
//    -> if_gnt 1 cycle, mem_req 3 cycles, if_rvalid 1 cycle with 0x00500093, dm_rvalid 0.
//  2 Store: dm_we=1, be=4'b0011, addr=0x2000, wdata=0xDEADBEEF, mem_ready immediate
//    -> mem_be=0011, mem_wdata=0xDEADBEEF, dm_rvalid pulse, dm_rdata=0.
//  3 Contention: if_req and dm_req high together, repeated 4 transactions.
//    Without RR_EN: DM,DM,... while dm_req is held.
//    With RR_EN: DM,IF,DM,IF (last_owner reset IF).
//  4 Back-to-back: dm_req held through a fetch -> dm_gnt exactly in the first IDLE cycle after
//    if_rvalid. mem_addr stable throughout WAIT_MEM.
//  5 Reset mid-op: RSTn low during WAIT_MEM (addr 0x300) -> mem_req 0 asynchronously,
//    no rvalid. After release, new if_req 0x304 completes normally.
//  6 Spurious: mem_ready high in IDLE with no req -> no rvalid, state stays IDLE.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Package: mem_arb_pkg
// Shared definitions for the unified memory-port arbiter.
//   state_e   : arbiter FSM encoding (IDLE / WAIT_MEM / RESP)
//   OWN_IF/DM : transaction owner encoding (1 bit)
//   be_width  : byte-enable width for a given data width
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    WAIT_MEM = 2'd1,
    RESP     = 2'd2
  } state_e;

  localparam logic OWN_IF = 1'b0;
  localparam logic OWN_DM = 1'b1;

  function automatic int unsigned be_width(input int unsigned data_w);
    return data_w / 8;
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Module: mem_arb_pick
// Combinational requester selection for the memory-port arbiter.
// Ports:
//   if_req     in  fetch request
//   dm_req     in  load/store request
//   last_owner in  owner of the most recent grant (OWN_IF / OWN_DM)
//   sel_if     out fetch requester selected
//   sel_dm     out load/store requester selected
// Build option: MEM_ARB_RR_EN selects round-robin on contention (the
// requester that was not last_owner wins); otherwise DM has fixed priority
// and last_owner is not consulted. A lone requester always wins.
module mem_arb_pick
  import mem_arb_pkg::*;
(
  input  logic if_req,
  input  logic dm_req,
  input  logic last_owner,
  output logic sel_if,
  output logic sel_dm
);

`ifdef MEM_ARB_RR_EN
  always_comb begin
    sel_if = 1'b0;
    sel_dm = 1'b0;
    if (if_req && dm_req) begin
      if (last_owner == OWN_DM) sel_if = 1'b1;
      else                      sel_dm = 1'b1;
    end else begin
      sel_if = if_req;
      sel_dm = dm_req;
    end
  end
`else
  // Fixed priority: last_owner is intentionally unused in this build.
  logic unused_last_owner;
  assign unused_last_owner = last_owner;

  always_comb begin
    sel_dm = dm_req;
    sel_if = if_req & ~dm_req;
  end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Module: mem_port_arbiter
// Shares one unified memory port between the instruction-fetch requester
// (IF) and the load/store requester (DM). The winner's request is latched
// and driven to memory until mem_ready; read data / write ack is returned
// to the owner only.
// Ports:
//   CLK, RSTn                    clock (rising edge), async active-low reset
//   if_req/if_addr               fetch request (always a full-word read)
//   if_gnt/if_rvalid/if_rdata    fetch accept, response pulse, fetched word
//   dm_req/dm_we/dm_be/dm_addr/dm_wdata  load/store request
//   dm_gnt/dm_rvalid/dm_rdata    load/store accept, response pulse, load data
//   mem_req/mem_we/mem_be/mem_addr/mem_wdata  latched memory request
//   mem_ready/mem_rdata          memory completion and read data
//   arb_busy                     transaction outstanding (state != IDLE)
//   dbg_state                    current FSM state
// Build option: MEM_ARB_RR_EN adds a last_owner register (reset to IF) and
// round-robin selection on contention; default is fixed DM priority.
//
// Handshake: a requester holds req and payload stable until it sees gnt
// high in the same cycle; the request is consumed on that clock edge.
// gnt is only ever given in IDLE. Dropping req before gnt withdraws it.
// The memory side sees mem_req high with a stable payload until a cycle
// with mem_ready high, which completes the transaction. The owner then
// gets exactly one rvalid cycle.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                          CLK,
  input  logic                          RSTn,
  input  logic                          if_req,
  input  logic [ADDR_W-1:0]             if_addr,
  output logic                          if_gnt,
  output logic                          if_rvalid,
  output logic [DATA_W-1:0]             if_rdata,
  input  logic                          dm_req,
  input  logic                          dm_we,
  input  logic [be_width(DATA_W)-1:0]   dm_be,
  input  logic [ADDR_W-1:0]             dm_addr,
  input  logic [DATA_W-1:0]             dm_wdata,
  output logic                          dm_gnt,
  output logic                          dm_rvalid,
  output logic [DATA_W-1:0]             dm_rdata,
  output logic                          mem_req,
  output logic                          mem_we,
  output logic [be_width(DATA_W)-1:0]   mem_be,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  input  logic                          mem_ready,
  input  logic [DATA_W-1:0]             mem_rdata,
  output logic                          arb_busy,
  output state_e                        dbg_state
);

  localparam int unsigned BE_W = be_width(DATA_W);

  state_e              state_q, state_d;
  logic                owner_q, owner_d;
  logic                we_q, we_d;
  logic [BE_W-1:0]     be_q, be_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
  logic [DATA_W-1:0]   dm_rdata_q, dm_rdata_d;

  logic sel_if, sel_dm;
  logic last_owner;
  logic if_gnt_c, dm_gnt_c;

  mem_arb_pick u_pick (
    .if_req     (if_req),
    .dm_req     (dm_req),
    .last_owner (last_owner),
    .sel_if     (sel_if),
    .sel_dm     (sel_dm)
  );

  // Grants exist only in IDLE; while reset is asserted they are held low
  // even though the state register already reads IDLE.
  assign if_gnt_c = (state_q == IDLE) & sel_if;
  assign dm_gnt_c = (state_q == IDLE) & sel_dm;
  assign if_gnt   = if_gnt_c & RSTn;
  assign dm_gnt   = dm_gnt_c & RSTn;

`ifdef MEM_ARB_RR_EN
  logic last_owner_q, last_owner_d;

  always_comb begin
    last_owner_d = last_owner_q;
    if (dm_gnt_c)      last_owner_d = OWN_DM;
    else if (if_gnt_c) last_owner_d = OWN_IF;
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) last_owner_q <= OWN_IF;
    else       last_owner_q <= last_owner_d;
  end

  assign last_owner = last_owner_q;
`else
  assign last_owner = OWN_IF;
`endif

  // Next-state and payload/response capture.
  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    we_d       = we_q;
    be_d       = be_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    dm_rdata_d = dm_rdata_q;

    unique case (state_q)
      IDLE: begin
        if (dm_gnt_c) begin
          owner_d = OWN_DM;
          we_d    = dm_we;
          be_d    = dm_be;
          addr_d  = dm_addr;
          wdata_d = dm_wdata;
          state_d = WAIT_MEM;
        end else if (if_gnt_c) begin
          owner_d = OWN_IF;
          we_d    = 1'b0;
          be_d    = '1;
          addr_d  = if_addr;
          wdata_d = '0;
          state_d = WAIT_MEM;
        end
      end
      WAIT_MEM: begin
        if (mem_ready) begin
          // Response lands in the owner's register on the edge into RESP,
          // so it is visible exactly when rvalid rises.
          if (owner_q == OWN_DM) dm_rdata_d = we_q ? '0 : mem_rdata;
          else                   if_rdata_d = mem_rdata;
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      state_q    <= IDLE;
      owner_q    <= OWN_IF;
      we_q       <= 1'b0;
      be_q       <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      if_rdata_q <= '0;
      dm_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      we_q       <= we_d;
      be_q       <= be_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      if_rdata_q <= if_rdata_d;
      dm_rdata_q <= dm_rdata_d;
    end
  end

  assign mem_req   = (state_q == WAIT_MEM);
  assign mem_we    = we_q;
  assign mem_be    = be_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;

  assign if_rvalid = (state_q == RESP) & (owner_q == OWN_IF);
  assign dm_rvalid = (state_q == RESP) & (owner_q == OWN_DM);
  assign if_rdata  = if_rdata_q;
  assign dm_rdata  = dm_rdata_q;

  assign arb_busy  = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  import mem_arb_pkg::*;

  localparam int AW = 32;
  localparam int DW = 32;
`ifdef MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RSTn = 1'b0;
  always #5 CLK = ~CLK;

  logic          if_req = 1'b0;
  logic [AW-1:0] if_addr = '0;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          dm_req = 1'b0;
  logic          dm_we = 1'b0;
  logic [3:0]    dm_be = '0;
  logic [AW-1:0] dm_addr = '0;
  logic [DW-1:0] dm_wdata = '0;
  logic          dm_gnt, dm_rvalid;
  logic [DW-1:0] dm_rdata;
  logic          mem_req, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic          mem_ready = 1'b0;
  logic [DW-1:0] mem_rdata = '0;
  logic          arb_busy;
  state_e        dbg_state;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .CLK       (CLK),
    .RSTn      (RSTn),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .if_rdata  (if_rdata),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_be     (dm_be),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .dm_rdata  (dm_rdata),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_be    (mem_be),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_ready (mem_ready),
    .mem_rdata (mem_rdata),
    .arb_busy  (arb_busy),
    .dbg_state (dbg_state)
  );

  // ---------------- scoreboard counters ----------------
  int passed = 0;
  int failed = 0;
  int total  = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // cyc: move just past the next rising edge (inputs are driven here).
  // smp: move to the falling edge (outputs are sampled here).
  task automatic cyc();
    @(posedge CLK);
    #1;
  endtask

  task automatic smp();
    @(negedge CLK);
  endtask

  task automatic reset_pulse();
    if_req = 1'b0; dm_req = 1'b0; mem_ready = 1'b0;
    RSTn = 1'b0;
    cyc();
    cyc();
    RSTn = 1'b1;
  endtask

  logic [DW-1:0] exp_q[$];
  bit            dm_wins;

  initial begin
    // ---------- reset state (gnt forced low even with requests up) ----------
    if_req = 1'b1; dm_req = 1'b1; if_addr = 32'h10; dm_addr = 32'h20;
    smp();
    check("rst_if_gnt", if_gnt, 0);
    check("rst_dm_gnt", dm_gnt, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_busy", arb_busy, 0);
    check("rst_if_rdata", if_rdata, 0);
    check("rst_dm_rvalid", dm_rvalid, 0);
    cyc();
    if_req = 1'b0; dm_req = 1'b0;
    RSTn = 1'b1;

    // ---------- 1: fetch only, mem_ready on 3rd mem_req cycle ----------
    cyc();
    if_req = 1'b1; if_addr = 32'h100;
    smp();
    check("t1_if_gnt", if_gnt, 1);
    check("t1_dm_gnt", dm_gnt, 0);
    check("t1_mreq_gnt_cycle", mem_req, 0);
    cyc();
    if_req = 1'b0;
    smp();
    check("t1_mreq_c1", mem_req, 1);
    check("t1_if_gnt_wait", if_gnt, 0);
    check("t1_addr", mem_addr, 32'h100);
    check("t1_we", mem_we, 0);
    check("t1_be", mem_be, 4'hF);
    check("t1_state_wait", dbg_state, WAIT_MEM);
    cyc();
    smp();
    check("t1_mreq_c2", mem_req, 1);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h0050_0093;
    smp();
    check("t1_mreq_c3", mem_req, 1);
    check("t1_no_early_rvalid", if_rvalid, 0);
    cyc();
    mem_ready = 1'b0; mem_rdata = 32'hFFFF_FFFF;
    smp();
    check("t1_if_rvalid", if_rvalid, 1);
    check("t1_if_rdata", if_rdata, 32'h0050_0093);
    check("t1_dm_rvalid", dm_rvalid, 0);
    check("t1_mreq_resp", mem_req, 0);
    cyc();
    smp();
    check("t1_rvalid_pulse", if_rvalid, 0);
    check("t1_idle", arb_busy, 0);

    // ---------- 2: store, mem_ready immediate ----------
    cyc();
    dm_req = 1'b1; dm_we = 1'b1; dm_be = 4'b0011; dm_addr = 32'h2000; dm_wdata = 32'hDEAD_BEEF;
    smp();
    check("t2_dm_gnt", dm_gnt, 1);
    cyc();
    dm_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h1234_5678;
    smp();
    check("t2_mem_we", mem_we, 1);
    check("t2_mem_be", mem_be, 4'b0011);
    check("t2_mem_wdata", mem_wdata, 32'hDEAD_BEEF);
    check("t2_mem_addr", mem_addr, 32'h2000);
    cyc();
    mem_ready = 1'b0;
    smp();
    check("t2_dm_rvalid", dm_rvalid, 1);
    check("t2_dm_rdata", dm_rdata, 0);
    check("t2_if_rvalid", if_rvalid, 0);
    check("t2_if_rdata_hold", if_rdata, 32'h0050_0093);
    cyc();
    smp();
    check("t2_dm_rvalid_pulse", dm_rvalid, 0);

    // ---------- 3: contention, 4 transactions ----------
    reset_pulse();
    dm_we = 1'b0; dm_be = 4'hF; if_addr = 32'h500;
    if_req = 1'b1; dm_req = 1'b1;
    smp();
    for (int i = 0; i < 4; i++) begin
      dm_wins = RR ? (i % 2 == 0) : 1'b1;
      dm_addr = 32'h6000 + 32'(i * 4);
      exp_q.push_back(32'hA000_0000 + 32'(i));
      check($sformatf("t3_dm_gnt_%0d", i), dm_gnt, dm_wins);
      check($sformatf("t3_if_gnt_%0d", i), if_gnt, !dm_wins);
      cyc();
      mem_ready = 1'b1; mem_rdata = 32'hA000_0000 + 32'(i);
      smp();
      check($sformatf("t3_addr_%0d", i), mem_addr, dm_wins ? 32'h6000 + 32'(i * 4) : 32'h500);
      cyc();
      mem_ready = 1'b0;
      smp();
      check($sformatf("t3_dm_rvalid_%0d", i), dm_rvalid, dm_wins);
      check($sformatf("t3_if_rvalid_%0d", i), if_rvalid, !dm_wins);
      check($sformatf("t3_rdata_%0d", i), dm_wins ? dm_rdata : if_rdata, exp_q.pop_front());
      cyc();
      if (i == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      smp();
    end
    check("t3_idle_after", arb_busy, 0);

    // ---------- 4: back-to-back, dm_req held through a fetch ----------
    cyc();
    if_req = 1'b1; if_addr = 32'h400;
    smp();
    check("t4_if_gnt", if_gnt, 1);
    cyc();
    if_req = 1'b0;
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h3000;
    smp();
    check("t4_dm_wait_c1", dm_gnt, 0);
    check("t4_addr_c1", mem_addr, 32'h400);
    cyc();
    smp();
    check("t4_dm_wait_c2", dm_gnt, 0);
    check("t4_addr_c2", mem_addr, 32'h400);
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h1111_2222;
    smp();
    check("t4_addr_c3", mem_addr, 32'h400);
    cyc();
    mem_ready = 1'b0;
    smp();
    check("t4_if_rvalid", if_rvalid, 1);
    check("t4_if_rdata", if_rdata, 32'h1111_2222);
    check("t4_no_gnt_resp", dm_gnt, 0);
    cyc();
    smp();
    check("t4_dm_gnt_first_idle", dm_gnt, 1);
    cyc();
    dm_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'h3333_4444;
    smp();
    check("t4_dm_addr", mem_addr, 32'h3000);
    cyc();
    mem_ready = 1'b0;
    smp();
    check("t4_dm_rvalid", dm_rvalid, 1);
    check("t4_dm_rdata", dm_rdata, 32'h3333_4444);

    // ---------- 5: reset during WAIT_MEM ----------
    cyc();
    if_req = 1'b1; if_addr = 32'h300;
    smp();
    check("t5_if_gnt", if_gnt, 1);
    cyc();
    if_req = 1'b0;
    smp();
    check("t5_mreq", mem_req, 1);
    check("t5_addr", mem_addr, 32'h300);
    #1;
    RSTn = 1'b0;
    #1;
    check("t5_mreq_async", mem_req, 0);
    check("t5_busy_async", arb_busy, 0);
    mem_ready = 1'b1; mem_rdata = 32'hBAD0_BAD0;
    cyc();
    mem_ready = 1'b0;
    RSTn = 1'b1;
    smp();
    check("t5_no_rvalid", if_rvalid, 0);
    check("t5_state_idle", dbg_state, IDLE);
    cyc();
    if_req = 1'b1; if_addr = 32'h304;
    smp();
    check("t5_new_gnt", if_gnt, 1);
    cyc();
    if_req = 1'b0;
    mem_ready = 1'b1; mem_rdata = 32'hCAFE_0001;
    smp();
    check("t5_new_addr", mem_addr, 32'h304);
    cyc();
    mem_ready = 1'b0;
    smp();
    check("t5_new_rvalid", if_rvalid, 1);
    check("t5_new_rdata", if_rdata, 32'hCAFE_0001);

    // ---------- 6: spurious mem_ready in IDLE ----------
    cyc();
    mem_ready = 1'b1; mem_rdata = 32'h5555_AAAA;
    smp();
    check("t6_state_c1", dbg_state, IDLE);
    cyc();
    smp();
    check("t6_if_rvalid", if_rvalid, 0);
    check("t6_dm_rvalid", dm_rvalid, 0);
    check("t6_state_c2", dbg_state, IDLE);
    check("t6_mreq", mem_req, 0);
    check("t6_if_rdata_hold", if_rdata, 32'hCAFE_0001);
    cyc();
    mem_ready = 1'b0;
    smp();

    // ---------- report ----------
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
